// File: rtl/ibex_multdiv_arbiter.sv
// rtl/ibex_multdiv_arbiter.sv - two-requester round-robin front end for a shared multdiv unit
module ibex_multdiv_arbiter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [3:0]       req_operator_i,
    input  logic [3:0]       req_signed_mode_i,
    input  logic [63:0]      req_op_a_i,
    input  logic [63:0]      req_op_b_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [CNT_W-1:0] rsp_cycles_o,
    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic             md_mult_sel_o,
    output logic             md_div_sel_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    output logic             md_ready_id_o,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic             last_grant;
    logic             idx;
    logic [1:0]       op_q;
    logic [1:0]       sm_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      result_q;
    logic [CNT_W-1:0] cycles_q;
    logic             grant_idx;
    logic             accept;
    logic             busy;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid_i == 2'b10) begin
            grant_idx = 1'b1;
        end else if (req_valid_i == 2'b11) begin
            grant_idx = ~last_grant;
        end
    end

    assign accept   = (state == IDLE) && (|req_valid_i);
    assign busy     = (state == BUSY);
    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            idx        <= 1'b0;
            op_q       <= 2'b00;
            sm_q       <= 2'b00;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            cnt        <= '0;
            result_q   <= 32'd0;
            cycles_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx        <= grant_idx;
                        last_grant <= grant_idx;
                        op_q       <= grant_idx ? req_operator_i[3:2]    : req_operator_i[1:0];
                        sm_q       <= grant_idx ? req_signed_mode_i[3:2] : req_signed_mode_i[1:0];
                        a_q        <= grant_idx ? req_op_a_i[63:32]      : req_op_a_i[31:0];
                        b_q        <= grant_idx ? req_op_b_i[63:32]      : req_op_b_i[31:0];
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // The count reported includes the cycle the result arrives.
                    cnt <= cnt_next;
                    if (md_valid_i) begin
                        result_q <= md_result_i;
                        cycles_q <= cnt_next;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[idx]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = accept ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid_o      = (state == RESP) ? (idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result_o     = result_q;
    assign rsp_cycles_o     = cycles_q;
    assign md_mult_en_o     = busy & ~op_q[1];
    assign md_mult_sel_o    = busy & ~op_q[1];
    assign md_div_en_o      = busy & op_q[1];
    assign md_div_sel_o     = busy & op_q[1];
    assign md_ready_id_o    = busy;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = sm_q;
    assign md_op_a_o        = a_q;
    assign md_op_b_o        = b_q;

endmodule

// File: doc/ibex_multdiv_arbiter.md
IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 Parameter CNT_W, default 6: width of the per-operation latency counter.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-004 req_valid_i  input  2  request valid, bit i belongs to requester i.
REQ-005 req_ready_o  output  2  request accept, one-hot or zero.
REQ-006 req_operator_i  input  4  MD operator per requester: bits [2i+1:2i]; 0=MULL, 1=MULH, 2=DIV, 3=REM.
REQ-007 req_signed_mode_i  input  4  signed mode per requester: bits [2i+1:2i].
REQ-008 req_op_a_i  input  64  operand A per requester: bits [32i+31:32i].
REQ-009 req_op_b_i  input  64  operand B per requester: bits [32i+31:32i].
REQ-010 rsp_valid_o  output  2  response valid, one-hot or zero.
REQ-011 rsp_ready_i  input  2  response accept per requester.
REQ-012 rsp_result_o  output  32  captured result, shared by both requesters.
REQ-013 rsp_cycles_o  output  CNT_W  execute-cycle count for the response.
REQ-014 md_mult_en_o  output  1  multiplier enable to the multdiv unit.
REQ-015 md_div_en_o  output  1  divider enable to the multdiv unit.
REQ-016 md_mult_sel_o  output  1  multiplier select to the multdiv unit.
REQ-017 md_div_sel_o  output  1  divider select to the multdiv unit.
REQ-018 md_operator_o  output  2  operator to the multdiv unit.
REQ-019 md_signed_mode_o  output  2  signed mode to the multdiv unit.
REQ-020 md_op_a_o  output  32  operand A to the multdiv unit.
REQ-021 md_op_b_o  output  32  operand B to the multdiv unit.
REQ-022 md_ready_id_o  output  1  consumer-ready to the multdiv unit.
REQ-023 md_valid_i  input  1  unit result valid.
REQ-024 md_result_i  input  32  unit result.

Function
REQ-025 FSM states SHALL be IDLE, BUSY and RESP.
REQ-026 IDLE: with any req_valid_i bit set, the arbiter SHALL assert req_ready_o for exactly one requester, latch that requester's operator, signed mode, op_a, op_b and index, clear the counter, and go to BUSY.
REQ-027 Arbitration SHALL be round-robin: a single requester wins alone; when both are valid, the requester not granted last wins; last_grant updates on every accept.
REQ-028 req_ready_o SHALL be 0 in BUSY and RESP.
REQ-029 BUSY: the md_* operator, signed mode and operands SHALL be driven from the latched values, held stable for the whole operation.
REQ-030 BUSY, multiply (latched operator[1]=0): md_mult_en_o=md_mult_sel_o=1 and md_div_en_o=md_div_sel_o=0.
REQ-031 BUSY, divide (latched operator[1]=1): md_div_en_o=md_div_sel_o=1 and md_mult_en_o=md_mult_sel_o=0.
REQ-032 md_ready_id_o SHALL be 1 in BUSY and 0 otherwise, so the unit never holds in its final state.
REQ-033 Outside BUSY, all md enables and selects SHALL be 0; md operand and operator outputs SHALL retain the latched values.
REQ-034 The counter SHALL increment every BUSY cycle, including the md_valid_i cycle, and saturate at 2^CNT_W-1.
REQ-035 BUSY with md_valid_i=1: capture md_result_i into rsp_result_o and the final count into rsp_cycles_o, then go to RESP.
REQ-036 md_valid_i outside BUSY SHALL be ignored.
REQ-037 RESP: rsp_valid_o SHALL be asserted for the latched index only, with result and count held stable until the matching rsp_ready_i is high, then go to IDLE.
REQ-038 rsp_ready_i for the non-granted index SHALL be ignored.
REQ-039 Latency: accept at cycle T, BUSY from T+1, md_valid_i at T+k (k>=1), rsp_valid_o from T+k+1.
REQ-040 Back-to-back: a response accepted at cycle R allows the next grant no earlier than R+1 (one IDLE cycle).
REQ-041 A request arriving during BUSY or RESP SHALL wait without loss.
REQ-042 Requesters SHALL hold request signals stable until accepted; the arbiter does not buffer unaccepted requests.

Reset
REQ-043 With rst_i high at a clock edge, the next state SHALL be IDLE, last_grant=1 (requester 0 wins the first tie), and counter=0.
REQ-044 After that reset, req_ready_o, rsp_valid_o, all md enables and selects, md_ready_id_o, rsp_result_o, rsp_cycles_o, md_operator_o, md_signed_mode_o, md_op_a_o and md_op_b_o SHALL all be 0.
REQ-045 Reset during BUSY or RESP SHALL abort the operation with no response; the multdiv unit is reset by its own reset.

Verification
REQ-046 req0 MULL, op_a=3, op_b=5; stub raises md_valid_i with 15 on the 3rd BUSY cycle -> rsp_valid_o=01, rsp_result_o=15, rsp_cycles_o=3, one cycle after md_valid_i.
REQ-047 Both requesters valid continuously from reset -> grants alternate 0,1,0,1; each grant one cycle after the previous response is accepted.
REQ-048 req1 DIV (operator=2), op_a=100, op_b=7 -> md_div_en_o=md_div_sel_o=1, md_mult_en_o=0 throughout BUSY; rsp_valid_o=10 with result 14.
REQ-049 rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o, rsp_result_o and rsp_cycles_o stable, req_ready_o=00, md enables 0.
REQ-050 rst_i asserted in the 2nd BUSY cycle -> next cycle: IDLE, all outputs 0, no rsp_valid_o ever for that request.
REQ-051 md_valid_i delayed 70 BUSY cycles, CNT_W=6 -> rsp_cycles_o=63.
